// File: rtl/mem_rdata_responder.sv
// Read-return path of the banked SRAM controller: read detect, array-latency tracking pipe, response FIFO.
// Optional RESP_PARITY_EN adds per-entry parity (ODATA_PAR) and a sticky capture parity check (PAR_ERR).
module mem_rdata_responder #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int NBANK      = 64,
    parameter int DW         = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MEM_CE,
    input  logic                MEM_WEB,
    input  logic [NBANK-1:0]    MEM_CSB,
    input  logic [NBANK-1:0]    MEM_OEB,
    input  logic [5:0]          MEM_ODATA_SELECT,
    input  logic [NBANK*DW-1:0] BANK_ODATA,
`ifdef RESP_PARITY_EN
    input  logic [NBANK-1:0]    BANK_PAR,
    output logic                ODATA_PAR,
    output logic                PAR_ERR,
`endif
    output logic [DW-1:0]       ODATA,
    output logic                ODATA_VALID,
    input  logic                ODATA_READY,
    output logic                RD_BUSY,
    output logic                OVERFLOW,
    output logic [2:0]          INFLIGHT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [63:0]    csb_ext, oeb_ext;
    logic           rd_hit;

    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [5:0]        pipe_sel_q [RD_LAT];
    logic [5:0]        pipe_sel_d [RD_LAT];
    logic [2:0]        inflight_q, inflight_d;

    logic           cap_vld;
    logic [5:0]     cap_sel;
    logic [DW-1:0]  cap_data;

    logic [DW-1:0]  mem_q [FIFO_DEPTH];
    logic [DW-1:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_d;
    logic           full, pop, push_ok, drop;
    logic [DW-1:0]  odata_q, odata_d;
    logic           odata_valid_q, odata_valid_d;
    logic           rd_busy_q, rd_busy_d;
    logic           overflow_q, overflow_d;

    // Unused select codes read as deselected, so sel >= NBANK never hits
    always_comb begin
        csb_ext = '1;
        oeb_ext = '1;
        csb_ext[NBANK-1:0] = MEM_CSB;
        oeb_ext[NBANK-1:0] = MEM_OEB;
        rd_hit = MEM_CE & MEM_WEB & ~csb_ext[MEM_ODATA_SELECT] & ~oeb_ext[MEM_ODATA_SELECT];
    end

    always_comb begin
        pipe_vld_d[0] = rd_hit;
        pipe_sel_d[0] = MEM_ODATA_SELECT;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_sel_d[i] = pipe_sel_q[i-1];
        end
        inflight_d = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_d = inflight_d + 3'(pipe_vld_d[i]);
        end
    end

    assign cap_vld  = pipe_vld_q[RD_LAT-1];
    assign cap_sel  = pipe_sel_q[RD_LAT-1];
    assign cap_data = BANK_ODATA[int'(cap_sel)*DW +: DW];

    // A pop frees the head slot this cycle, so a push into a full FIFO is still legal
    always_comb begin
        full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        pop      = odata_valid_q & ODATA_READY;
        push_ok  = cap_vld & (~full | pop);
        drop     = cap_vld & full & ~pop;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = cap_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = wr_ptr_d - rd_ptr_d;
        // Output register shows the head once its write has landed in storage
        odata_valid_d = (wr_ptr_q != rd_ptr_d);
        odata_d       = mem_q[rd_ptr_d[AW-1:0]];
        rd_busy_d     = (int'(occ_d) + int'(inflight_d)) >= (FIFO_DEPTH - 1);
        overflow_d    = overflow_q | drop;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_sel_q[i] <= '0;
            inflight_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            odata_q       <= '0;
            odata_valid_q <= 1'b0;
            rd_busy_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) pipe_sel_q[i] <= pipe_sel_d[i];
            inflight_q    <= inflight_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            odata_q       <= odata_d;
            odata_valid_q <= odata_valid_d;
            rd_busy_q     <= rd_busy_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign ODATA       = odata_q;
    assign ODATA_VALID = odata_valid_q;
    assign RD_BUSY     = rd_busy_q;
    assign OVERFLOW    = overflow_q;
    assign INFLIGHT    = inflight_q;

`ifdef RESP_PARITY_EN
    logic mem_par_q [FIFO_DEPTH];
    logic mem_par_d [FIFO_DEPTH];
    logic odata_par_q, odata_par_d;
    logic par_err_q, par_err_d;

    // Every capture is checked, including bytes that are then dropped
    always_comb begin
        mem_par_d = mem_par_q;
        if (push_ok) begin
            mem_par_d[wr_ptr_q[AW-1:0]] = ^cap_data;
        end
        odata_par_d = mem_par_q[rd_ptr_d[AW-1:0]];
        par_err_d   = par_err_q | (cap_vld & (BANK_PAR[cap_sel] != ^cap_data));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            odata_par_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            odata_par_q <= odata_par_d;
            par_err_q   <= par_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_par_q <= mem_par_d;
    end

    assign ODATA_PAR = odata_par_q;
    assign PAR_ERR   = par_err_q;
`endif

endmodule
